// File: rtl/demux_rr_fifo.sv
// demux_rr_fifo
//   1-to-NUM_CH byte demultiplexer for the lane-striping receive path. Input
//   words go to a lane picked round-robin (modo=0) or by selector (modo=1) and
//   are buffered in a per-lane show-ahead FIFO with a valid/pop handshake.
//
// Ports
//   clk_f          single clock, posedge
//   reset          asynchronous, active-high
//   entrada        input word
//   valid_entrada  input word valid
//   ready_entrada  word can be accepted this cycle (independent of valid)
//   modo           0 = round-robin, 1 = direct via selector
//   selector       target lane in direct mode (>= NUM_CH is invalid)
//   salida         lane i head word at [i*WIDTH +: WIDTH], 0 while empty
//   valid_salida   lane i head word valid
//   pop_salida     lane i consumes its head word
//   full / empty   lane i occupancy == DEPTH / == 0
//   cuenta         per-lane 16-bit accepted-word counters
//
// Optional feature: define DEMUX_CNT_EN to build the cuenta counters;
// otherwise cuenta is tied to 0 and the port list stays the same.

module demux_rr_fifo #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk_f,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        entrada,
  input  logic                    valid_entrada,
  output logic                    ready_entrada,
  input  logic                    modo,
  input  logic [SEL_W-1:0]        selector,
  output logic [NUM_CH*WIDTH-1:0] salida,
  output logic [NUM_CH-1:0]       valid_salida,
  input  logic [NUM_CH-1:0]       pop_salida,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       empty,
  output logic [NUM_CH*16-1:0]    cuenta
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);
  localparam logic [AW:0]      DEPTH_W = (AW + 1)'(DEPTH);

  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  target;
  logic [NUM_CH-1:0] lane_sel;
  logic              accept;

  assign target = modo ? selector : rr_ptr;

  // An out-of-range selector matches no lane, so ready drops without a
  // separate range check. Full lanes are never skipped: strict stripe order.
  assign ready_entrada = |(lane_sel & ~full);
  assign accept        = valid_entrada & ready_entrada;

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (accept && !modo) begin
      rr_ptr <= (rr_ptr == LAST_CH) ? '0 : rr_ptr + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      occ;
    logic             push;
    logic             pop;

    assign lane_sel[i] = (target == SEL_W'(i));
    assign push        = accept & lane_sel[i];
    // Pop on an empty lane is ignored, even if a push lands the same cycle.
    assign pop         = pop_salida[i] & (occ != '0);

    always_ff @(posedge clk_f or posedge reset) begin
      if (reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      occ <= occ + 1'b1;
        else if (pop && !push) occ <= occ - 1'b1;
      end
    end

    // Storage needs no reset: the head is masked by occupancy.
    always_ff @(posedge clk_f) begin
      if (push) mem[wr_ptr] <= entrada;
    end

    assign full[i]                   = (occ == DEPTH_W);
    assign empty[i]                  = (occ == '0);
    assign valid_salida[i]           = ~empty[i];
    assign salida[i*WIDTH +: WIDTH]  = empty[i] ? '0 : mem[rd_ptr];

`ifdef DEMUX_CNT_EN
    logic [15:0] cnt;

    always_ff @(posedge clk_f or posedge reset) begin
      if (reset)     cnt <= '0;
      else if (push) cnt <= cnt + 16'd1;
    end

    assign cuenta[i*16 +: 16] = cnt;
`else
    assign cuenta[i*16 +: 16] = 16'd0;
`endif
  end

endmodule

// File: tb/tb_demux_rr_fifo.sv
module tb_demux_rr_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  entrada;
  logic        vin;
  logic        rdy;
  logic        modo;
  logic [1:0]  sel;
  logic [31:0] salida;
  logic [3:0]  vs;
  logic [3:0]  pop;
  logic [3:0]  full;
  logic [3:0]  empty;
  logic [63:0] cuenta;

  // Second, 3-lane instance to reach an out-of-range selector value.
  logic        b_vin;
  logic        b_rdy;
  logic        b_modo;
  logic [1:0]  b_sel;
  logic [23:0] b_salida;
  logic [2:0]  b_vs;
  logic [2:0]  b_full;
  logic [2:0]  b_empty;
  logic [47:0] b_cuenta;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  demux_rr_fifo #(.WIDTH(8), .NUM_CH(4), .DEPTH(4)) dut (
    .clk_f(clk), .reset(rst), .entrada(entrada), .valid_entrada(vin),
    .ready_entrada(rdy), .modo(modo), .selector(sel), .salida(salida),
    .valid_salida(vs), .pop_salida(pop), .full(full), .empty(empty),
    .cuenta(cuenta)
  );

  demux_rr_fifo #(.WIDTH(8), .NUM_CH(3), .DEPTH(4)) dut3 (
    .clk_f(clk), .reset(rst), .entrada(8'h77), .valid_entrada(b_vin),
    .ready_entrada(b_rdy), .modo(b_modo), .selector(b_sel), .salida(b_salida),
    .valid_salida(b_vs), .pop_salida(3'b000), .full(b_full), .empty(b_empty),
    .cuenta(b_cuenta)
  );

  // Reference model: one queue per lane, a round-robin index and counters.
  byte unsigned q[4][$];
  int           rr;
  int           cnt[4];

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      cnt[i] = 0;
    end
    rr = 0;
  endtask

  function automatic bit m_ready(bit md, int s);
    int tgt;
    tgt = md ? s : rr;
    if (tgt >= 4) return 1'b0;
    return q[tgt].size() < 4;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [31:0] e_sal;
    logic [3:0]  e_vs, e_full, e_empty;
    logic [63:0] e_cnt;
    for (int i = 0; i < 4; i++) begin
      e_sal[i*8 +: 8] = (q[i].size() > 0) ? q[i][0] : 8'h00;
      e_vs[i]         = q[i].size() > 0;
      e_full[i]       = q[i].size() == 4;
      e_empty[i]      = q[i].size() == 0;
`ifdef DEMUX_CNT_EN
      e_cnt[i*16 +: 16] = 16'(cnt[i]);
`else
      e_cnt[i*16 +: 16] = 16'h0;
`endif
    end
    check("salida", {32'h0, salida}, {32'h0, e_sal});
    check("valid_salida", {60'h0, vs}, {60'h0, e_vs});
    check("full", {60'h0, full}, {60'h0, e_full});
    check("empty", {60'h0, empty}, {60'h0, e_empty});
    check("cuenta", cuenta, e_cnt);
  endtask

  // One cycle: drive at negedge, check ready, update model, clock, check.
  task automatic step(input bit v, input bit md, input logic [1:0] s,
                      input logic [7:0] d, input logic [3:0] p,
                      output bit rdy_seen);
    bit r;
    int tgt;
    @(negedge clk);
    vin = v; modo = md; sel = s; entrada = d; pop = p;
    #1;
    rdy_seen = rdy;
    r = m_ready(md, s);
    check("ready", {63'h0, rdy}, {63'h0, r});
    tgt = md ? int'(s) : rr;
    for (int i = 0; i < 4; i++)
      if (p[i] && q[i].size() > 0) void'(q[i].pop_front());
    if (v && r) begin
      q[tgt].push_back(d);
      cnt[tgt] = (cnt[tgt] + 1) & 16'hFFFF;
      if (!md) rr = (rr + 1) % 4;
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; vin = 1'b0; pop = 4'h0; modo = 1'b0; sel = 2'd0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit         v;
    bit         md;
    logic [1:0] s;
    logic [7:0] d;
    logic [3:0] p;
    bit         exp_rdy;
    logic [3:0] exp_vs;
    logic [7:0] exp_l0;
  } vec_t;

  vec_t tbl[12];
  bit   r_seen;

  initial begin
    tbl[0]  = '{1, 0, 2'd0, 8'h01, 4'h0, 1, 4'b0001, 8'h01};
    tbl[1]  = '{1, 0, 2'd0, 8'h02, 4'h0, 1, 4'b0011, 8'h01};
    tbl[2]  = '{1, 0, 2'd0, 8'h03, 4'h0, 1, 4'b0111, 8'h01};
    tbl[3]  = '{1, 0, 2'd0, 8'h04, 4'h0, 1, 4'b1111, 8'h01};
    tbl[4]  = '{0, 0, 2'd0, 8'h00, 4'hF, 1, 4'b0000, 8'h00};
    tbl[5]  = '{1, 1, 2'd0, 8'hA0, 4'h0, 1, 4'b0001, 8'hA0};
    tbl[6]  = '{1, 1, 2'd0, 8'hA1, 4'h0, 1, 4'b0001, 8'hA0};
    tbl[7]  = '{1, 1, 2'd0, 8'hA2, 4'h0, 1, 4'b0001, 8'hA0};
    tbl[8]  = '{1, 1, 2'd0, 8'hA3, 4'h0, 1, 4'b0001, 8'hA0};
    tbl[9]  = '{1, 1, 2'd0, 8'hA4, 4'h0, 0, 4'b0001, 8'hA0};
    tbl[10] = '{1, 1, 2'd0, 8'hA4, 4'h1, 0, 4'b0001, 8'hA1};
    tbl[11] = '{1, 1, 2'd0, 8'hA4, 4'h0, 1, 4'b0001, 8'hA1};

    rst = 1'b1; vin = 1'b0; modo = 1'b0; sel = 2'd0; entrada = 8'h00; pop = 4'h0;
    b_vin = 1'b0; b_modo = 1'b0; b_sel = 2'd0;
    model_clear();
    #12;
    check_model();
    check("reset_ready", {63'h0, rdy}, 64'h1);
    @(negedge clk);
    rst = 1'b0;

    // Table: round-robin striping, then direct fill / stall / pop of lane 0.
    for (int k = 0; k < 12; k++) begin
      step(tbl[k].v, tbl[k].md, tbl[k].s, tbl[k].d, tbl[k].p, r_seen);
      check($sformatf("tbl%0d_ready", k), {63'h0, r_seen}, {63'h0, tbl[k].exp_rdy});
      check($sformatf("tbl%0d_vs", k), {60'h0, vs}, {60'h0, tbl[k].exp_vs});
      check($sformatf("tbl%0d_lane0", k), {56'h0, salida[7:0]}, {56'h0, tbl[k].exp_l0});
    end

    // Round-robin stalls on a full lane without skipping it.
    do_reset();
    step(1, 0, 2'd0, 8'h10, 4'h0, r_seen);
    for (int k = 0; k < 4; k++) step(1, 1, 2'd1, 8'(8'h20 + k), 4'h0, r_seen);
    step(1, 0, 2'd0, 8'h30, 4'h0, r_seen);
    check("rr_stall_ready", {63'h0, r_seen}, 64'h0);
    step(1, 0, 2'd0, 8'h30, 4'h0, r_seen);
    check("rr_stall_lane2", {60'h0, empty}, 64'hC);
    step(1, 0, 2'd0, 8'h30, 4'b0010, r_seen);
    check("full_pop_no_pass", {63'h0, r_seen}, 64'h0);
    step(1, 0, 2'd0, 8'h30, 4'h0, r_seen);
    check("rr_resume_lane1", {63'h0, r_seen}, 64'h1);
    step(1, 0, 2'd0, 8'h31, 4'h0, r_seen);
    check("rr_then_lane2", {56'h0, salida[23:16]}, 64'h31);

    // Asynchronous reset between edges with data buffered.
    @(negedge clk);
    vin = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_clear();
    check("async_vs", {60'h0, vs}, 64'h0);
    check("async_empty", {60'h0, empty}, 64'hF);
    check("async_salida", {32'h0, salida}, 64'h0);
    check("async_cuenta", cuenta, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Push and pop on the same lane at occupancy 1.
    step(1, 1, 2'd2, 8'h50, 4'h0, r_seen);
    step(1, 1, 2'd2, 8'h51, 4'b0100, r_seen);
    check("pushpop_lane2", {56'h0, salida[23:16]}, 64'h51);
    check("pushpop_occ", {62'h0, full[2], empty[2]}, 64'h0);
    // Push and pop on an empty lane: the pop is dropped.
    step(1, 1, 2'd3, 8'h60, 4'b1000, r_seen);
    check("pushpop_empty", {56'h0, salida[31:24]}, 64'h60);

    // Out-of-range selector on the 3-lane instance.
    @(negedge clk);
    b_modo = 1'b1; b_sel = 2'd3; b_vin = 1'b1;
    #1 check("sel_invalid_ready", {63'h0, b_rdy}, 64'h0);
    @(posedge clk); #1;
    check("sel_invalid_nopush", {61'h0, b_empty}, 64'h7);
    @(negedge clk);
    b_sel = 2'd2;
    #1 check("sel_valid_ready", {63'h0, b_rdy}, 64'h1);
    b_vin = 1'b0;

    // Counters after five round-robin words.
    do_reset();
    for (int k = 0; k < 5; k++) step(1, 0, 2'd0, 8'(8'h70 + k), 4'h0, r_seen);
`ifdef DEMUX_CNT_EN
    check("cuenta_5w", cuenta, {16'd1, 16'd1, 16'd1, 16'd2});
`else
    check("cuenta_5w", cuenta, 64'h0);
`endif

    // Random traffic against the queue model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           2'($urandom_range(0, 3)), 8'($urandom), 4'($urandom), r_seen);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
